mem_test_ctrl: RTL and testbench
================================

// Module: mem_test_ctrl
// PURPOSE
//  Control FSM for the 32k x 16 SRAM march tester. It sits directly upstream
//  of the supplemental datapath (address/data registers, pattern mux, error
//  latch) and drives that datapath's pass, loadA, loadD and state inputs. It
//  consumes the datapath's done, finish and error outputs and generates the
//  active-low SRAM strobes. Each of the four passes writes all 32768 words,
//  then reads and compares all 32768 words.
// PARAMETERS
//  WRITE_CYC    2  cycles we_n held low per word (>=1)
//  READ_WAIT    2  cycles oe_n held low before the compare cycle (>=1)
//  STOP_ON_ERR  0  1: abort to DONE on the first latched error; 0: run all passes
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  start      in   1  level; sampled in IDLE only
//  done       in   1  datapath: address register == 15'h7FFF
//  finish     in   1  datapath: pass == 3'b100
//  error      in   1  datapath: sticky mismatch flag, registered
//  pass       out  3  current pass 0..4, to datapath pattern mux
//  loadA      out  1  increment datapath address register
//  loadD      out  1  load datapath write-data register
//  state      out  3  encoded FSM state; datapath compares only in 3'b100
//  ce_n       out  1  SRAM chip enable, active low
//  we_n       out  1  SRAM write enable, active low
//  oe_n       out  1  SRAM output enable, active low
//  busy       out  1  high from leaving IDLE until DONE is entered
//  test_done  out  1  high while in DONE
//  fail       out  1  error value captured on entry to DONE
// BEHAVIOUR
//  Reset: state=IDLE(000), pass=0, ce_n=we_n=oe_n=1, busy=0, test_done=0,
//   fail=0, wait counter=0. Reset acts immediately, including mid-pass.
//  State encoding (state port = FSM register, Moore outputs):
//   000 IDLE   : all strobes high. start=1 -> W_INC.
//   001 W_INC  : loadA=1 -> W_LD.
//   010 W_LD   : loadD=1, ce_n=0 -> W_STB. Wait counter cleared.
//   011 W_STB  : ce_n=0, we_n=0 for WRITE_CYC cycles. On the last cycle:
//                done=1 -> R_INC, else -> W_INC.
//   101 R_INC  : loadA=1 -> R_LD.
//   110 R_LD   : loadD=1, ce_n=0, oe_n=0 for READ_WAIT cycles -> R_CMP.
//   100 R_CMP  : ce_n=0, oe_n=0, exactly 1 cycle; datapath compares here.
//                done=0 -> R_INC. done=1 -> pass<=pass+1, then
//                pass==3 -> DONE, else -> W_INC.
//   111 DONE   : terminal; strobes high. Only rst leaves DONE.
//  loadA and loadD are never asserted in the same cycle. loadD in W_LD/R_LD
//   follows the address update, so the pattern mux sees the new address.
//  Address sequence: the datapath resets its address to 7FFF. The first
//   W_INC wraps it to 0. The last write is at 7FFF, and R_INC then wraps to 0.
//  Pass increments only in R_CMP with done=1, so W_LD of the next pass uses
//   the new pattern. finish is not used for sequencing. In DONE, finish=1 is
//   expected unless the run aborted.
//  STOP_ON_ERR=1: in W_INC or R_INC, error=1 -> DONE in the next cycle.
//   loadA is suppressed in that cycle, and pass holds its value.
//  fail <= error on the transition into DONE. busy=0 and test_done=1 from the
//   first DONE cycle onward.
//  Cycles per word: 2+WRITE_CYC (write), 2+READ_WAIT (read). With defaults a
//   pass is 8*32768=262144 cycles and the full test is 1048576 cycles + 1.
//  The wait counter is sized ceil(log2(max(WRITE_CYC,READ_WAIT)+1)) and
//   saturates/clears on state exit. It never wraps inside a state.
// TESTING
//  1 Reset: rst pulse mid-clock -> all outputs at reset values immediately;
//    state=000, pass=0; start held low -> stays IDLE indefinitely.
//  2 First word: start=1 with a datapath model -> W_INC, W_LD, W_STB x2,
//    W_INC; we_n low exactly 2 cycles; address=0, wdata=16'hFFFF at we_n rise.
//  3 Phase turn: after the write at 7FFF -> R_INC, R_LD x2, R_CMP; oe_n low
//    3 cycles; loadA/loadD never both 1 across the whole run.
//  4 Full run, fault-free SRAM model -> pass steps 0,1,2,3,4; test_done rises
//    at cycle 1048577 after start; fail=0; finish=1.
//  5 Stuck bit (bit 3 of address 0x0100 stuck at 0), STOP_ON_ERR=1 -> DONE
//    in pass 0 read phase at address 0x0100; fail=1; pass=0; no further
//    loadA.
//  6 Same fault, STOP_ON_ERR=0 -> all 4 passes complete; fail=1;
//    rst in pass 2 -> IDLE, pass=0, strobes high.

Source files
------------

// File: rtl/mem_test_ctrl.sv
// Control FSM for the 32k x 16 SRAM march tester. It runs four write/read-compare
// passes through the external datapath and drives the active-low SRAM strobes.
module mem_test_ctrl #(
  parameter int WRITE_CYC   = 2,
  parameter int READ_WAIT   = 2,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       done,
  input  logic       finish,
  input  logic       error,
  output logic [2:0] pass,
  output logic       loadA,
  output logic       loadD,
  output logic [2:0] state,
  output logic       ce_n,
  output logic       we_n,
  output logic       oe_n,
  output logic       busy,
  output logic       test_done,
  output logic       fail
);

  localparam int MAX_WAIT = (WRITE_CYC > READ_WAIT) ? WRITE_CYC : READ_WAIT;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  localparam logic [CW-1:0] WR_LAST  = CW'(WRITE_CYC - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] WAIT_TOP = CW'(MAX_WAIT);

  // Encoding is visible on the state port; the datapath compares only in R_CMP.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_W_INC = 3'b001,
    S_W_LD  = 3'b010,
    S_W_STB = 3'b011,
    S_R_CMP = 3'b100,
    S_R_INC = 3'b101,
    S_R_LD  = 3'b110,
    S_DONE  = 3'b111
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    pass_q, pass_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          fail_q, fail_d;
  logic          abort;
  logic          unused_finish;

  // finish is informational only; sequencing is driven by done and pass.
  assign unused_finish = finish;
  assign abort         = STOP_ON_ERR && error;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pass_q  <= 3'd0;
      wait_q  <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      wait_q  <= wait_d;
      fail_q  <= fail_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    wait_d  = '0;
    fail_d  = fail_q;
    loadA   = 1'b0;
    loadD   = 1'b0;
    ce_n    = 1'b1;
    we_n    = 1'b1;
    oe_n    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_W_INC;
      end
      S_W_INC: begin
        if (abort) begin
          state_d = S_DONE;
        end else begin
          loadA   = 1'b1;
          state_d = S_W_LD;
        end
      end
      S_W_LD: begin
        loadD   = 1'b1;
        ce_n    = 1'b0;
        state_d = S_W_STB;
      end
      S_W_STB: begin
        ce_n = 1'b0;
        we_n = 1'b0;
        if (wait_q == WR_LAST) begin
          state_d = done ? S_R_INC : S_W_INC;
        end else begin
          wait_d = (wait_q == WAIT_TOP) ? wait_q : wait_q + 1'b1;
        end
      end
      S_R_INC: begin
        if (abort) begin
          state_d = S_DONE;
        end else begin
          loadA   = 1'b1;
          state_d = S_R_LD;
        end
      end
      S_R_LD: begin
        loadD = 1'b1;
        ce_n  = 1'b0;
        oe_n  = 1'b0;
        if (wait_q == RD_LAST) begin
          state_d = S_R_CMP;
        end else begin
          wait_d = (wait_q == WAIT_TOP) ? wait_q : wait_q + 1'b1;
        end
      end
      S_R_CMP: begin
        ce_n = 1'b0;
        oe_n = 1'b0;
        if (done) begin
          pass_d  = pass_q + 3'd1;
          state_d = (pass_q == 3'd3) ? S_DONE : S_W_INC;
        end else begin
          state_d = S_R_INC;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Sticky verdict is whatever the datapath has latched when DONE is entered.
    if (state_d == S_DONE && state_q != S_DONE) fail_d = error;
  end

  assign state     = state_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign test_done = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_test_ctrl.sv
// Self-checking bench for mem_test_ctrl: two controllers (run-all and stop-on-error)
// drive a scaled-down datapath + SRAM model with randomized stuck-bit faults.
module tb_mem_test_ctrl;

  localparam int AW    = 4;
  localparam int N     = 1 << AW;
  localparam int LIMIT = 1500;

  logic clk;
  logic rst;
  logic start;
  logic run_active;
  logic chk_req;
  int   chk_mode;

  bit   fault_en;
  int   fault_addr;
  int   fault_bit;
  bit   fault_val;

  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int p, input int a);
    logic [15:0] base;
    case (p)
      0:       base = 16'hFFFF;
      1:       base = 16'h0000;
      2:       base = 16'hAAAA;
      default: base = 16'h5555;
    endcase
    return base ^ 16'(a);
  endfunction

  function automatic logic [15:0] apply_fault(input int a, input logic [15:0] d);
    logic [15:0] v;
    v = d;
    if (fault_en && a == fault_addr) v[fault_bit] = fault_val;
    return v;
  endfunction

  // First pass whose pattern disagrees with the stuck value; 4 means never.
  function automatic int first_bad_pass();
    logic [15:0] v;
    if (!fault_en) return 4;
    for (int p = 0; p < 4; p++) begin
      v = pat(p, fault_addr);
      if (v[fault_bit] != fault_val) return p;
    end
    return 4;
  endfunction

  function automatic logic [31:0] seq_state(input int k);
    case (k)
      0:       return 32'd1;
      1:       return 32'd2;
      2:       return 32'd3;
      3:       return 32'd3;
      default: return 32'd1;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int WC   = (g == 0) ? 2 : 3;
    localparam int RW   = (g == 0) ? 2 : 1;
    localparam bit STOP = (g == 1);

    logic [2:0]    pass, state, prev_pass;
    logic          loada, loadd, ce_n, we_n, oe_n, busy, test_done, fail;
    logic          done, finish, error;
    logic [AW-1:0] addr;
    logic [15:0]   wdata, rdata;
    logic [15:0]   mem [N];
    logic          prev_we, prev_oe, both_seen, la_done;
    int            cyc, we_len, oe_len, wcount, rcount;
    int            bp, exp_cyc, exp_pass, per_pass;
    bit            exp_finish, aborted;

    mem_test_ctrl #(
      .WRITE_CYC  (WC),
      .READ_WAIT  (RW),
      .STOP_ON_ERR(STOP)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .done     (done),
      .finish   (finish),
      .error    (error),
      .pass     (pass),
      .loadA    (loada),
      .loadD    (loadd),
      .state    (state),
      .ce_n     (ce_n),
      .we_n     (we_n),
      .oe_n     (oe_n),
      .busy     (busy),
      .test_done(test_done),
      .fail     (fail)
    );

    assign done   = (addr == AW'(N - 1));
    assign finish = (pass == 3'd4);
    assign rdata  = mem[addr];

    // Datapath + SRAM model: address/data registers, pattern mux, sticky error.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        addr  <= '1;
        wdata <= '0;
        error <= 1'b0;
      end else begin
        if (loada) addr <= addr + 1'b1;
        if (loadd) wdata <= pat(int'(pass), int'(addr));
        if (!ce_n && !we_n) mem[addr] <= apply_fault(int'(addr), wdata);
        if (state == 3'b100 && !oe_n && rdata != wdata) error <= 1'b1;
      end
    end

    always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else if (run_active && !test_done) cyc <= cyc + 1;
    end

    always @(negedge clk or posedge rst) begin
      if (rst) begin
        prev_we   <= 1'b1;
        prev_oe   <= 1'b1;
        prev_pass <= 3'd0;
        we_len    <= 0;
        oe_len    <= 0;
        wcount    <= 0;
        rcount    <= 0;
        both_seen <= 1'b0;
        la_done   <= 1'b0;
      end else begin
        prev_we   <= we_n;
        prev_oe   <= oe_n;
        prev_pass <= pass;
        if (!we_n) we_len <= we_len + 1;
        if (!oe_n) oe_len <= oe_len + 1;
        if (we_n && !prev_we) begin
          check($sformatf("i%0d we_n low cycles", g), 32'(we_len), 32'(WC));
          check($sformatf("i%0d write addr", g), 32'(addr), 32'(wcount % N));
          check($sformatf("i%0d write data", g), 32'(wdata), 32'(pat(wcount / N, wcount % N)));
          we_len <= 0;
          wcount <= wcount + 1;
        end
        if (oe_n && !prev_oe) begin
          check($sformatf("i%0d oe_n low cycles", g), 32'(oe_len), 32'(RW + 1));
          check($sformatf("i%0d read addr", g), 32'(addr), 32'(rcount % N));
          oe_len <= 0;
          rcount <= rcount + 1;
        end
        if (pass != prev_pass)
          check($sformatf("i%0d pass step", g), 32'(pass), 32'(prev_pass) + 32'd1);
        if (loada && loadd) both_seen <= 1'b1;
        if (test_done && loada) la_done <= 1'b1;
      end
    end

    always @(posedge chk_req) begin
      case (chk_mode)
        1: begin
          check($sformatf("i%0d rst state", g), 32'(state), 32'd0);
          check($sformatf("i%0d rst pass", g), 32'(pass), 32'd0);
          check($sformatf("i%0d rst strobes", g), 32'({ce_n, we_n, oe_n}), 32'd7);
          check($sformatf("i%0d rst flags", g), 32'({busy, test_done, fail, loada, loadd}), 32'd0);
        end
        2: begin
          bp       = first_bad_pass();
          per_pass = N * (4 + WC + RW);
          aborted  = STOP && (bp < 4);
          if (aborted) begin
            exp_cyc    = bp * per_pass + N * (2 + WC) + (fault_addr + 1) * (2 + RW) + 2;
            exp_pass   = bp;
            exp_finish = 1'b0;
          end else begin
            exp_cyc    = 4 * per_pass + 1;
            exp_pass   = 4;
            exp_finish = 1'b1;
          end
          check($sformatf("i%0d test_done", g), 32'(test_done), 32'd1);
          check($sformatf("i%0d busy at end", g), 32'(busy), 32'd0);
          check($sformatf("i%0d state at end", g), 32'(state), 32'd7);
          check($sformatf("i%0d cycles to done", g), 32'(cyc), 32'(exp_cyc));
          check($sformatf("i%0d pass at end", g), 32'(pass), 32'(exp_pass));
          check($sformatf("i%0d fail", g), 32'(fail), 32'(bp < 4));
          check($sformatf("i%0d finish", g), 32'(finish), 32'(exp_finish));
          check($sformatf("i%0d strobes at end", g), 32'({ce_n, we_n, oe_n}), 32'd7);
          check($sformatf("i%0d loadA/loadD overlap", g), 32'(both_seen), 32'd0);
          check($sformatf("i%0d loadA in DONE", g), 32'(la_done), 32'd0);
          if (aborted) check($sformatf("i%0d abort addr", g), 32'(addr), 32'(fault_addr));
        end
        3: begin
          check($sformatf("i%0d idle state", g), 32'(state), 32'd0);
          check($sformatf("i%0d idle busy", g), 32'(busy), 32'd0);
          check($sformatf("i%0d idle strobes", g), 32'({ce_n, we_n, oe_n}), 32'd7);
        end
        default: ;
      endcase
    end
  end

  task automatic pulse_chk(input int m);
    chk_mode = m;
    chk_req  = 1'b1;
    #1;
    chk_req  = 1'b0;
  endtask

  // Mid-cycle reset pulse; outputs are checked while rst is still high.
  task automatic do_reset();
    @(negedge clk);
    start      = 1'b0;
    run_active = 1'b0;
    #2 rst = 1'b1;
    #1 pulse_chk(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_trial(input bit fen, input int fa, input int fb, input bit fv, input bit seq);
    int n;
    fault_en   = fen;
    fault_addr = fa;
    fault_bit  = fb;
    fault_val  = fv;
    do_reset();
    repeat ($urandom_range(1, 8)) @(negedge clk);
    start      = 1'b1;
    run_active = 1'b1;
    if (seq) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("first word state", 32'(g_dut[0].state), seq_state(k));
      end
    end
    n = 0;
    while (!(g_dut[0].test_done && g_dut[1].test_done) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    pulse_chk(2);
    start      = 1'b0;
    run_active = 1'b0;
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    start      = 1'b0;
    run_active = 1'b0;
    chk_req    = 1'b0;
    chk_mode   = 0;
    fault_en   = 1'b0;
    fault_addr = 0;
    fault_bit  = 0;
    fault_val  = 1'b0;

    #12 pulse_chk(1);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    pulse_chk(3);

    run_trial(1'b0, 0, 0, 1'b0, 1'b1);
    run_trial(1'b1, 4, 3, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++)
      run_trial(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 2)),
                int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);

    // Reset in the middle of pass 2 of a faulty run.
    fault_en   = 1'b1;
    fault_addr = 4;
    fault_bit  = 3;
    fault_val  = 1'b0;
    do_reset();
    @(negedge clk);
    start      = 1'b1;
    run_active = 1'b1;
    n = 0;
    while (g_dut[0].pass != 3'd2 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("reach pass 2", 32'(g_dut[0].pass), 32'd2);
    repeat ($urandom_range(1, 60)) @(negedge clk);
    #3 rst = 1'b1;
    #1 pulse_chk(1);
    start      = 1'b0;
    run_active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    pulse_chk(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
